// File: rtl/adsr_env.sv
// adsr_env: four-stage ADSR envelope generator feeding a VCA control input.
// The level lives in a WIDTH+FRAC bit fixed-point accumulator; cv is its
// integer part. The stage machine advances on gate edges and sample ticks.
// Optional build macro: ADSR_EXP_RELEASE_EN selects an exponential-style
// release (decrement grows with the current level); undefined gives linear.
module adsr_env #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic                  gate,
  input  logic [WIDTH+FRAC-1:0] attack_rate,
  input  logic [WIDTH+FRAC-1:0] decay_rate,
  input  logic [WIDTH-1:0]      sustain_level,
  input  logic [WIDTH+FRAC-1:0] release_rate,
  output logic [WIDTH-1:0]      cv,
  output logic [2:0]            state,
  output logic                  active
);

  localparam int ACC_W = WIDTH + FRAC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  // Widen an accumulator-sized value by one bit so sums cannot wrap.
  function automatic logic [ACC_W:0] f_widen(input logic [ACC_W-1:0] v);
    return {1'b0, v};
  endfunction

  // Release decrement for the current level, computed one bit wide so a
  // large rate still lands in the clamp-to-zero branch.
  function automatic logic [ACC_W:0] f_release_dec(input logic [ACC_W-1:0] acc,
                                                   input logic [ACC_W-1:0] rate);
`ifdef ADSR_EXP_RELEASE_EN
    return f_widen(acc >> 3'd6) + f_widen(rate);
`else
    return f_widen(rate) + f_widen(acc & ACC_ZERO);
`endif
  endfunction

  // Stage machine and accumulator state
  state_t             r_fsm;
  logic [ACC_W-1:0]   r_acc;
  logic               r_gate_q;

  // Registered outputs, one clock behind the core state
  logic [WIDTH-1:0]   r_cv;
  logic [2:0]         r_state;
  logic               r_active;

  // Next-state combinational signals
  state_t             w_fsm_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic               w_rise;
  logic               w_fall;
  logic [ACC_W-1:0]   w_sus;
  logic [ACC_W:0]     w_att_sum;
  logic [ACC_W:0]     w_dec_lim;
  logic [ACC_W:0]     w_rel_dec;
  logic               w_held;

  assign w_rise    = gate & ~r_gate_q;
  assign w_fall    = ~gate & r_gate_q;
  assign w_sus     = {sustain_level, {FRAC{1'b0}}};
  assign w_att_sum = f_widen(r_acc) + f_widen(attack_rate);
  assign w_dec_lim = f_widen(w_sus) + f_widen(decay_rate);
  assign w_rel_dec = f_release_dec(r_acc, release_rate);
  assign w_held    = (r_fsm == ST_ATTACK) || (r_fsm == ST_DECAY) ||
                     (r_fsm == ST_SUSTAIN);

  // Gate history register used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_q <= 1'b0;
    end else begin
      r_gate_q <= gate;
    end
  end

  // Stage and accumulator update: gate edges first, then tick arithmetic
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_acc_nxt = r_acc;
    if (w_rise) begin
      // Retrigger keeps the current level; no jump to zero.
      w_fsm_nxt = ST_ATTACK;
    end else if (w_fall && w_held) begin
      w_fsm_nxt = ST_RELEASE;
    end else if (sample_en) begin
      case (r_fsm)
        ST_IDLE: begin
          w_acc_nxt = ACC_ZERO;
        end
        ST_ATTACK: begin
          if (w_att_sum >= f_widen(ACC_MAX)) begin
            w_acc_nxt = ACC_MAX;
            w_fsm_nxt = ST_DECAY;
          end else begin
            w_acc_nxt = w_att_sum[ACC_W-1:0];
          end
        end
        ST_DECAY: begin
          if (f_widen(r_acc) <= w_dec_lim) begin
            w_acc_nxt = w_sus;
            w_fsm_nxt = ST_SUSTAIN;
          end else begin
            w_acc_nxt = r_acc - decay_rate;
          end
        end
        ST_SUSTAIN: begin
          // Follows live changes of sustain_level on every tick.
          w_acc_nxt = w_sus;
        end
        ST_RELEASE: begin
          if (f_widen(r_acc) <= w_rel_dec) begin
            w_acc_nxt = ACC_ZERO;
            w_fsm_nxt = ST_IDLE;
          end else begin
            // Here the decrement is below acc, so its top bit is clear.
            w_acc_nxt = r_acc - w_rel_dec[ACC_W-1:0];
          end
        end
        default: begin
          w_acc_nxt = ACC_ZERO;
          w_fsm_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_fsm_nxt = r_fsm;
      w_acc_nxt = r_acc;
    end
  end

  // Core state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= ST_IDLE;
      r_acc <= ACC_ZERO;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_acc <= w_acc_nxt;
    end
  end

  // Output registers: publish the core state one clock later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cv     <= {WIDTH{1'b0}};
      r_state  <= 3'd0;
      r_active <= 1'b0;
    end else begin
      r_cv     <= r_acc[ACC_W-1:FRAC];
      r_state  <= r_fsm;
      r_active <= (r_fsm != ST_IDLE);
    end
  end

  assign cv     = r_cv;
  assign state  = r_state;
  assign active = r_active;

endmodule

// File: tb/tb_adsr_env.sv
// Directed testbench for adsr_env (default WIDTH=8, FRAC=16).
// Inputs are driven just after the falling edge; outputs are checked on
// falling edges. One sample tick is issued per 4-clock slot.
module tb_adsr_env;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic        gate;
  logic [23:0] attack_rate;
  logic [23:0] decay_rate;
  logic [7:0]  sustain_level;
  logic [23:0] release_rate;
  logic [7:0]  cv;
  logic [2:0]  state;
  logic        active;

  int checks = 0;
  int errors = 0;

  adsr_env #(.WIDTH(8), .FRAC(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_en     (sample_en),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .cv            (cv),
    .state         (state),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp_cv,
                         input logic [2:0] exp_st, input logic exp_act);
    chk({tag, ".cv"}, {24'd0, cv}, {24'd0, exp_cv});
    chk({tag, ".state"}, {29'd0, state}, {29'd0, exp_st});
    chk({tag, ".active"}, {31'd0, active}, {31'd0, exp_act});
  endtask

  // One 4-clock slot with a tick in its first cycle.
  task automatic tick();
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One 4-clock slot with no tick.
  task automatic slot();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] prev_cv;
    int         n;
    logic       mono_bad;

    rst_n         = 1'b0;
    sample_en     = 1'b0;
    gate          = 1'b1;
    attack_rate   = 24'h100000;
    decay_rate    = 24'h100000;
    sustain_level = 8'h80;
    release_rate  = 24'h080000;

    // Reset held with gate high
    repeat (3) @(negedge clk);
    chk_out("reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel1.state", {29'd0, state}, 32'd0);
    @(negedge clk);
    chk_out("rel2", 8'h00, 3'd1, 1'b1);
    @(negedge clk);
    @(negedge clk);

    // Attack: 0x10 per tick, 16th tick saturates
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk_out($sformatf("att%0d", k), 8'(16 * k), 3'd1, 1'b1);
    end
    tick();
    chk_out("att16", 8'hFF, 3'd2, 1'b1);

    // Decay toward sustain 0x80
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_out($sformatf("dec%0d", k), 8'(8'hFF - 16 * k), 3'd2, 1'b1);
    end
    tick();
    chk_out("dec8", 8'h80, 3'd3, 1'b1);

    // Live sustain change is followed at the next tick only
    sustain_level = 8'h40;
    slot();
    chk("sus_notick.cv", {24'd0, cv}, 32'h80);
    tick();
    chk_out("sus40", 8'h40, 3'd3, 1'b1);
    sustain_level = 8'h80;
    tick();
    chk_out("sus80", 8'h80, 3'd3, 1'b1);

`ifndef ADSR_EXP_RELEASE_EN
    // Linear release, partway down to 0x40
    gate = 1'b0;
    slot();
    chk_out("fall", 8'h80, 3'd4, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_out($sformatf("relA%0d", k), 8'(8'h80 - 8 * k), 3'd4, 1'b1);
    end

    // Retrigger with the edge on a tick: edge consumes the tick
    gate = 1'b1;
    tick();
    chk_out("retrig", 8'h40, 3'd1, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk_out($sformatf("ratt%0d", k), 8'(8'h40 + 16 * k), 3'd1, 1'b1);
    end
    tick();
    chk_out("ratt12", 8'hFF, 3'd2, 1'b1);
    repeat (7) tick();
    chk_out("rdec7", 8'h8F, 3'd2, 1'b1);
    tick();
    chk_out("rdec8", 8'h80, 3'd3, 1'b1);

    // Full linear release with the fall on a tick
    gate = 1'b0;
    tick();
    chk_out("fall_tick", 8'h80, 3'd4, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk_out($sformatf("rel%0d", k), 8'(8'h80 - 8 * k), 3'd4, 1'b1);
    end
    tick();
    chk_out("rel16", 8'h00, 3'd0, 1'b0);
    tick();
    chk_out("idle_tick", 8'h00, 3'd0, 1'b0);

    // Zero attack rate holds the level
    gate = 1'b1;
    slot();
    chk_out("za_rise", 8'h00, 3'd1, 1'b1);
    repeat (3) tick();
    chk_out("za3", 8'h30, 3'd1, 1'b1);
    attack_rate = 24'h000000;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk(  "za_hold.cv", {24'd0, cv}, 32'h30);
      chk("za_hold.state", {29'd0, state}, 32'd1);
    end

    // Zero release rate holds, then a rate equal to acc clamps to zero
    gate = 1'b0;
    release_rate = 24'h000000;
    slot();
    chk_out("zr_fall", 8'h30, 3'd4, 1'b1);
    repeat (5) tick();
    chk_out("zr_hold", 8'h30, 3'd4, 1'b1);
    release_rate = 24'h300000;
    tick();
    chk_out("zr_clamp", 8'h00, 3'd0, 1'b0);

    // Full-scale rates saturate without wrapping
    attack_rate = 24'hFFFFFF;
    decay_rate  = 24'hFFFFFF;
    gate = 1'b1;
    slot();
    tick();
    chk_out("sat_att", 8'hFF, 3'd2, 1'b1);
    tick();
    chk_out("sat_dec", 8'h80, 3'd3, 1'b1);
`else
    // Exponential release from full scale
    sustain_level = 8'hFF;
    tick();
    chk_out("exp_top", 8'hFF, 3'd3, 1'b1);
    gate = 1'b0;
    release_rate = 24'h000100;
    slot();
    chk_out("exp_fall", 8'hFF, 3'd4, 1'b1);
    n = 0;
    mono_bad = 1'b0;
    while (state != 3'd0 && n < 4000) begin
      prev_cv = cv;
      tick();
      if (cv > prev_cv) mono_bad = 1'b1;
      n++;
    end
    chk("exp_mono", {31'd0, mono_bad}, 32'd0);
    chk("exp_idle", {29'd0, state}, 32'd0);
    chk("exp_faster", {31'd0, (n < 65280) ? 1'b1 : 1'b0}, 32'd1);
    gate = 1'b1;
    attack_rate = 24'hFFFFFF;
    decay_rate  = 24'hFFFFFF;
    sustain_level = 8'h80;
    slot();
    tick();
    tick();
    chk_out("exp_sus", 8'h80, 3'd3, 1'b1);
`endif

    // Asynchronous reset mid-envelope, gate held high through release
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arel1.state", {29'd0, state}, 32'd0);
    @(negedge clk);
    chk_out("arel2", 8'h00, 3'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
